// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) to one-slave memory arbiter: data has priority, a burst limit protects fetch.
// m_req_o rises the cycle after grant; one ack/err pulse follows m_ack_i or timeout; masters hold req while busy.
module mem_arbiter #(
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        f_req_i,
   input  logic [31:0] f_addr_i,
   output logic [31:0] f_rdata_o,
   output logic        f_ack_o,
   output logic        f_err_o,
   input  logic        d_req_i,
   input  logic        d_wen_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   input  logic [3:0]  d_wmask_i,
   output logic [31:0] d_rdata_o,
   output logic        d_ack_o,
   output logic        d_err_o,
   output logic        m_req_o,
   output logic        m_wen_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   output logic [3:0]  m_wmask_o,
   input  logic [31:0] m_rdata_i,
   input  logic        m_ack_i,
   output logic        busy_o
);

   localparam int unsigned BW = $clog2(BURST_MAX + 1);
   localparam logic [15:0]    TO_LAST   = 16'(TIMEOUT - 1);
   localparam logic [BW-1:0]  BURST_LIM = BW'(BURST_MAX);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mreq_t;

   state_t        state_q, state_d;
   mreq_t         mreq_q, mreq_d;
   logic          own_d_q, own_d_d;   // 1 = data master owns the transaction
   logic          err_q, err_d;
   logic [15:0]   tcnt_q, tcnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          grant_f;
   logic          grant_d;

   // Fetch wins only when data is idle or has used up its burst allowance.
   assign grant_f = f_req_i && (!d_req_i || (bcnt_q == BURST_LIM));
   assign grant_d = d_req_i && !grant_f;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_f || grant_d) state_d = REQ;
         REQ:     if (m_ack_i || (tcnt_q == TO_LAST)) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mreq_d  = mreq_q;
      own_d_d = own_d_q;
      err_d   = err_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_f) begin
               mreq_d  = '{wen: 1'b0, addr: f_addr_i, wdata: 32'h0, wmask: 4'hF};
               own_d_d = 1'b0;
               tcnt_d  = '0;
               bcnt_d  = '0;
            end else if (grant_d) begin
               mreq_d  = '{wen: d_wen_i, addr: d_addr_i, wdata: d_wdata_i, wmask: d_wmask_i};
               own_d_d = 1'b1;
               tcnt_d  = '0;
               if (!f_req_i) begin
                  bcnt_d = '0;
               end else if (bcnt_q != BURST_LIM) begin
                  bcnt_d = bcnt_q + BW'(1);
               end
            end
         end
         REQ: begin
            if (m_ack_i) begin
               rdata_d = m_rdata_i;
               err_d   = 1'b0;
            end else if (tcnt_q == TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mreq_q  <= '0;
         own_d_q <= 1'b0;
         err_q   <= 1'b0;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         rdata_q <= '0;
      end else begin
         mreq_q  <= mreq_d;
         own_d_q <= own_d_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs decode registered state only, so reset clears them without a clock.
   always_comb begin
      m_req_o = (state_q == REQ);
      busy_o  = (state_q != IDLE);
      f_ack_o = 1'b0;
      f_err_o = 1'b0;
      d_ack_o = 1'b0;
      d_err_o = 1'b0;
      if (state_q == RESP) begin
         if (own_d_q) begin
            d_ack_o = !err_q;
            d_err_o = err_q;
         end else begin
            f_ack_o = !err_q;
            f_err_o = err_q;
         end
      end
   end

   assign m_wen_o   = mreq_q.wen;
   assign m_addr_o  = mreq_q.addr;
   assign m_wdata_o = mreq_q.wdata;
   assign m_wmask_o = mreq_q.wmask;
   assign f_rdata_o = rdata_q;
   assign d_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds expected responses, a monitor pops them.
module tb_mem_arbiter;

   localparam int TO = 8;
   localparam int BM = 4;

   logic        clk;
   logic        rst;
   logic        f_req_i;
   logic [31:0] f_addr_i;
   logic [31:0] f_rdata_o;
   logic        f_ack_o;
   logic        f_err_o;
   logic        d_req_i;
   logic        d_wen_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [3:0]  d_wmask_i;
   logic [31:0] d_rdata_o;
   logic        d_ack_o;
   logic        d_err_o;
   logic        m_req_o;
   logic        m_wen_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [3:0]  m_wmask_o;
   logic [31:0] m_rdata_i;
   logic        m_ack_i;
   logic        busy_o;

   typedef struct {
      logic        data;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter #(.TIMEOUT(TO), .BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst),
      .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_rdata_o(f_rdata_o),
      .f_ack_o(f_ack_o), .f_err_o(f_err_o),
      .d_req_i(d_req_i), .d_wen_i(d_wen_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_wmask_i(d_wmask_i), .d_rdata_o(d_rdata_o),
      .d_ack_o(d_ack_o), .d_err_o(d_err_o),
      .m_req_o(m_req_o), .m_wen_o(m_wen_o), .m_addr_o(m_addr_o),
      .m_wdata_o(m_wdata_o), .m_wmask_o(m_wmask_o), .m_rdata_i(m_rdata_i),
      .m_ack_i(m_ack_i), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: every ack/err pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && (f_ack_o || f_err_o || d_ack_o || d_err_o)) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", {60'h0, f_ack_o, f_err_o, d_ack_o, d_err_o}, 64'h0);
         end else begin
            e = sb.pop_front();
            check("resp_flags", {60'h0, f_ack_o, f_err_o, d_ack_o, d_err_o},
                  e.data ? {62'h0, !e.err, e.err} : {60'h0, !e.err, e.err, 2'b00});
            check("resp_rdata", e.data ? d_rdata_o : f_rdata_o, e.rdata);
         end
      end
   end

   // Slave model: waits for m_req_o, checks the payload every REQ cycle, acks on cycle wait_n.
   task automatic slave_serve(input int wait_n, input bit give_ack, input logic [31:0] rd,
                              input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                              input logic [3:0] em, input int exp_cycles);
      int c;
      int spin;
      spin = 0;
      while (!m_req_o && spin < 20) begin
         @(negedge clk);
         spin++;
      end
      check("m_req_rise", {63'h0, m_req_o}, 64'h1);
      c = 0;
      while (m_req_o && c < TO + 4) begin
         c++;
         check("m_addr", {32'h0, m_addr_o}, {32'h0, ea});
         check("m_ctl", {26'h0, busy_o, m_wen_o, m_wmask_o, m_wdata_o}, {26'h0, 1'b1, ew, em, ewd});
         if (give_ack && c == wait_n) begin
            m_ack_i   = 1'b1;
            m_rdata_i = rd;
         end
         @(negedge clk);
         m_ack_i   = 1'b0;
         m_rdata_i = 32'h0;
      end
      check("req_cycles", 64'(c), 64'(exp_cycles));
   endtask

   task automatic check_idle(input string tag);
      check(tag, {59'h0, busy_o, f_ack_o, f_err_o, d_ack_o, d_err_o}, 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      f_req_i = 1'b0; f_addr_i = 32'h0;
      d_req_i = 1'b0; d_wen_i = 1'b0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_wmask_i = 4'h0;
      m_ack_i = 1'b0; m_rdata_i = 32'h0;

      // Reset state
      @(negedge clk);
      check("rst_m_req", {63'h0, m_req_o}, 64'h0);
      check_idle("rst_flags");
      check("rst_m_bus", {27'h0, m_wen_o, m_wmask_o, m_addr_o}, 64'h0);
      check("rst_rdata", {f_rdata_o, d_rdata_o}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single fetch, zero-wait slave
      f_req_i = 1'b1; f_addr_i = 32'h0000_0100;
      sb.push_back('{data: 1'b0, err: 1'b0, rdata: 32'hDEAD_BEEF});
      slave_serve(1, 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0, 4'hF, 1);
      f_req_i = 1'b0;
      @(negedge clk);
      check_idle("fetch_single_done");

      // Simultaneous requests: data store first, then fetch
      f_req_i = 1'b1; f_addr_i = 32'h10;
      d_req_i = 1'b1; d_wen_i = 1'b1; d_addr_i = 32'h2000; d_wdata_i = 32'h1234_5678; d_wmask_i = 4'b0011;
      sb.push_back('{data: 1'b1, err: 1'b0, rdata: 32'h0000_0000});
      sb.push_back('{data: 1'b0, err: 1'b0, rdata: 32'h1111_2222});
      slave_serve(1, 1'b1, 32'h0, 32'h2000, 1'b1, 32'h1234_5678, 4'b0011, 1);
      d_req_i = 1'b0;
      slave_serve(2, 1'b1, 32'h1111_2222, 32'h10, 1'b0, 32'h0, 4'hF, 2);
      f_req_i = 1'b0;
      @(negedge clk);
      check_idle("simul_done");

      // Starvation guard: D D D D F D
      f_req_i = 1'b1; f_addr_i = 32'h40;
      d_req_i = 1'b1; d_wen_i = 1'b0; d_wdata_i = 32'h0; d_wmask_i = 4'hF; d_addr_i = 32'h3000;
      for (int i = 0; i < BM; i++) begin
         sb.push_back('{data: 1'b1, err: 1'b0, rdata: 32'hA000_0000 + 32'(i)});
         slave_serve(1, 1'b1, 32'hA000_0000 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, 1);
         d_addr_i = 32'h3000 + 32'(4 * (i + 1));
      end
      check("burst_full", 64'(dut.bcnt_q), 64'(BM));
      sb.push_back('{data: 1'b0, err: 1'b0, rdata: 32'hF00D_0040});
      slave_serve(1, 1'b1, 32'hF00D_0040, 32'h40, 1'b0, 32'h0, 4'hF, 1);
      check("burst_after_fetch", 64'(dut.bcnt_q), 64'h0);
      f_req_i = 1'b0;
      sb.push_back('{data: 1'b1, err: 1'b0, rdata: 32'hA000_0010});
      slave_serve(1, 1'b1, 32'hA000_0010, 32'h3010, 1'b0, 32'h0, 4'hF, 1);
      d_req_i = 1'b0;
      @(negedge clk);
      check_idle("starve_done");

      // Timeout on a data load, then a stray late ack
      d_req_i = 1'b1; d_wen_i = 1'b0; d_addr_i = 32'h4000; d_wdata_i = 32'h0; d_wmask_i = 4'hF;
      sb.push_back('{data: 1'b1, err: 1'b1, rdata: 32'h0});
      slave_serve(0, 1'b0, 32'h0, 32'h4000, 1'b0, 32'h0, 4'hF, TO);
      d_req_i = 1'b0;
      @(negedge clk);
      check_idle("timeout_idle");
      m_ack_i = 1'b1; m_rdata_i = 32'h5555_5555;
      @(negedge clk);
      m_ack_i = 1'b0; m_rdata_i = 32'h0;
      check_idle("late_ack_ignored");
      @(negedge clk);
      check("late_ack_no_req", {62'h0, m_req_o, busy_o}, 64'h0);

      // Wait states: ack on the 5th REQ cycle
      d_req_i = 1'b1; d_wen_i = 1'b0; d_addr_i = 32'h5000; d_wdata_i = 32'h0; d_wmask_i = 4'hF;
      sb.push_back('{data: 1'b1, err: 1'b0, rdata: 32'hCAFE_F00D});
      slave_serve(5, 1'b1, 32'hCAFE_F00D, 32'h5000, 1'b0, 32'h0, 4'hF, 5);
      d_req_i = 1'b0;
      @(negedge clk);
      check_idle("wait_done");

      // Reset in the middle of REQ
      f_req_i = 1'b1; f_addr_i = 32'h600;
      for (int s = 0; s < 20 && !m_req_o; s++) @(negedge clk);
      check("rst_mid_req_seen", {63'h0, m_req_o}, 64'h1);
      #2 rst = 1'b1;
      #1 check("rst_async_drop", {62'h0, m_req_o, busy_o}, 64'h0);
      f_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("rst_release_idle");
      @(negedge clk);
      f_req_i = 1'b1; f_addr_i = 32'h700;
      sb.push_back('{data: 1'b0, err: 1'b0, rdata: 32'h0BAD_F00D});
      slave_serve(2, 1'b1, 32'h0BAD_F00D, 32'h700, 1'b0, 32'h0, 4'hF, 2);
      f_req_i = 1'b0;
      @(negedge clk);
      check_idle("post_rst_fetch_done");

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
